// File: rtl/ped_pkg.sv
// Shared types and default timing constants for the pedestrian crossing request unit.
package ped_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWalk,
        StFlash,
        StClear
    } ped_state_e;

    localparam int unsigned DEBOUNCE_CYC_DEF = 16;
    localparam int unsigned WALK_SEC_DEF     = 5;
    localparam int unsigned FLASH_SEC_DEF    = 3;
    localparam int unsigned CD_W             = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability-count debounce and
// a one-clock press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw_i;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any clock where the synchronized level agrees restarts the run.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request FSM: latches button presses, requests a crossing, then runs
// the walk and flashing don't-walk intervals with a safety abort on lost grant.
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned WALK_SEC     = WALK_SEC_DEF,
    parameter int unsigned FLASH_SEC    = FLASH_SEC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_raw,
    input  logic            tick,
    input  logic            grant,
    output logic            paso,
    output logic            walk,
    output logic            dont_walk,
    output logic            wait_led,
    output logic [CD_W-1:0] countdown
);

    logic btn_level;
    logic press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw_i(btn_raw),
        .level_o  (btn_level),
        .press_o  (press)
    );

    ped_state_e      state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            flash_dw_q, flash_dw_d;
    logic            pending_q, pending_d;
    logic            paso_q, paso_d;
    logic            walk_q, walk_d;
    logic            dont_walk_q, dont_walk_d;
    logic            wait_led_q, wait_led_d;

    // State register, including the registered lamp outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cd_q        <= '0;
            flash_dw_q  <= 1'b1;
            pending_q   <= 1'b0;
            paso_q      <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            wait_led_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            flash_dw_q  <= flash_dw_d;
            pending_q   <= pending_d;
            paso_q      <= paso_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            wait_led_q  <= wait_led_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cd_d       = cd_q;
        flash_dw_d = flash_dw_q;
        pending_d  = pending_q;
        if (press && (state_q == StFlash || state_q == StClear)) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (press) state_d = StReq;
            end
            StReq: begin
                if (grant) begin
                    state_d = StWalk;
                    cd_d    = CD_W'(WALK_SEC);
                end
            end
            StWalk: begin
                if (!grant) begin
                    state_d = StClear;
                    cd_d    = '0;
                end else if (tick) begin
                    if (cd_q == CD_W'(1)) begin
                        state_d    = StFlash;
                        cd_d       = CD_W'(FLASH_SEC);
                        flash_dw_d = 1'b1;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end
            StFlash: begin
                if (!grant) begin
                    state_d = StClear;
                    cd_d    = '0;
                end else if (tick) begin
                    if (cd_q == CD_W'(1)) begin
                        state_d = StClear;
                        cd_d    = '0;
                    end else begin
                        cd_d       = cd_q - CD_W'(1);
                        flash_dw_d = ~flash_dw_q;
                    end
                end
            end
            StClear: begin
                if (!grant) state_d = pending_d ? StReq : StIdle;
            end
            default: begin
                state_d = StIdle;
                cd_d    = '0;
            end
        endcase
        if (state_d == StReq) pending_d = 1'b0;
    end

    // Output logic: decoded from the next state so every lamp is a flop.
    always_comb begin
        paso_d      = (state_d == StReq);
        walk_d      = (state_d == StWalk);
        dont_walk_d = (state_d == StFlash) ? flash_dw_d : (state_d != StWalk);
        wait_led_d  = (state_d == StReq) ||
                      (pending_d && (state_d == StFlash || state_d == StClear));
    end

    assign paso      = paso_q;
    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign wait_led  = wait_led_q;
    assign countdown = cd_q;

    logic unused_level;
    assign unused_level = btn_level;

endmodule

// File: tb/tb_ped_request_unit.sv
// Self-checking bench for ped_request_unit: vector table plus hand sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_ped_request_unit;

    typedef struct packed {
        logic       paso;
        logic       walk;
        logic       dont_walk;
        logic       wait_led;
        logic [3:0] cd;
    } out_t;

    typedef struct packed {
        logic rst;
        logic btn;
        logic tick;
        logic grant;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic       tick = 1'b0;
    logic       grant = 1'b0;
    logic       paso, walk, dont_walk, wait_led;
    logic [3:0] countdown;

    int   n_vec = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    vec_t tbl[0:13];

    ped_request_unit #(
        .DEBOUNCE_CYC(4),
        .WALK_SEC    (5),
        .FLASH_SEC   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .tick     (tick),
        .grant    (grant),
        .paso     (paso),
        .walk     (walk),
        .dont_walk(dont_walk),
        .wait_led (wait_led),
        .countdown(countdown)
    );

    always #5 clk = ~clk;

    function automatic out_t o_idle();
        return '{paso: 1'b0, walk: 1'b0, dont_walk: 1'b1, wait_led: 1'b0, cd: 4'd0};
    endfunction
    function automatic out_t o_req();
        return '{paso: 1'b1, walk: 1'b0, dont_walk: 1'b1, wait_led: 1'b1, cd: 4'd0};
    endfunction
    function automatic out_t o_walk(input logic [3:0] n);
        return '{paso: 1'b0, walk: 1'b1, dont_walk: 1'b0, wait_led: 1'b0, cd: n};
    endfunction
    function automatic out_t o_flash(input logic [3:0] n, input logic d, input logic w);
        return '{paso: 1'b0, walk: 1'b0, dont_walk: d, wait_led: w, cd: n};
    endfunction
    function automatic out_t o_clear(input logic w);
        return '{paso: 1'b0, walk: 1'b0, dont_walk: 1'b1, wait_led: w, cd: 4'd0};
    endfunction

    function automatic vec_t mk(input logic r, input logic b, input logic t, input logic g,
                                input out_t e);
        return '{rst: r, btn: b, tick: t, grant: g, exp: e};
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
    task automatic apply(input vec_t v, input string name);
        out_t got, exp;
        @(negedge clk);
        rst     = v.rst;
        btn_raw = v.btn;
        tick    = v.tick;
        grant   = v.grant;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got = '{paso: paso, walk: walk, dont_walk: dont_walk, wait_led: wait_led,
                cd: countdown};
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got paso=%b walk=%b dw=%b wait=%b cd=%0d, want paso=%b walk=%b dw=%b wait=%b cd=%0d",
                     name, $time, got.paso, got.walk, got.dont_walk, got.wait_led, got.cd,
                     exp.paso, exp.walk, exp.dont_walk, exp.wait_led, exp.cd);
        end
    endtask

    initial begin
        // Full-cycle table, entered one cycle after WALK begins (cd=5).
        tbl[0]  = mk(0, 0, 0, 1, o_walk(5));
        tbl[1]  = mk(0, 0, 1, 1, o_walk(4));
        tbl[2]  = mk(0, 0, 0, 1, o_walk(4));
        tbl[3]  = mk(0, 0, 1, 1, o_walk(3));
        tbl[4]  = mk(0, 0, 1, 1, o_walk(2));
        tbl[5]  = mk(0, 0, 1, 1, o_walk(1));
        tbl[6]  = mk(0, 0, 1, 1, o_flash(3, 1, 0));
        tbl[7]  = mk(0, 0, 0, 1, o_flash(3, 1, 0));
        tbl[8]  = mk(0, 0, 1, 1, o_flash(2, 0, 0));
        tbl[9]  = mk(0, 0, 1, 1, o_flash(1, 1, 0));
        tbl[10] = mk(0, 0, 1, 1, o_clear(0));
        tbl[11] = mk(0, 0, 1, 1, o_clear(0));
        tbl[12] = mk(0, 0, 0, 0, o_idle());
        tbl[13] = mk(0, 0, 1, 0, o_idle());

        apply(mk(1, 0, 0, 0, o_idle()), "reset");
        apply(mk(1, 1, 1, 1, o_idle()), "reset_priority");

        // Bounce: toggle every 2 clks for 20 clks, then hold; press lands 2+4+1 later.
        for (int i = 0; i < 20; i++) apply(mk(0, ((i / 2) % 2) == 0, 0, 0, o_idle()), "bounce");
        for (int i = 1; i <= 6; i++) apply(mk(0, 1, 0, 0, o_idle()), "debounce_wait");
        apply(mk(0, 1, 0, 0, o_req()), "press_to_req");
        apply(mk(0, 1, 0, 0, o_req()), "req_hold1");
        apply(mk(0, 1, 1, 0, o_req()), "req_tick_ignored");
        apply(mk(0, 0, 0, 1, o_walk(5)), "grant_to_walk");
        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("full_cycle[%0d]", i));

        // Pending: new press, walk to FLASH, press during FLASH.
        for (int i = 1; i <= 6; i++) apply(mk(0, 1, 0, 0, o_idle()), "press2_wait");
        apply(mk(0, 1, 0, 0, o_req()), "press2_req");
        apply(mk(0, 0, 0, 1, o_walk(5)), "p_walk5");
        for (int i = 4; i >= 1; i--) apply(mk(0, 0, 1, 1, o_walk(4'(i))), "p_walk_tick");
        apply(mk(0, 0, 1, 1, o_flash(3, 1, 0)), "p_flash_entry");
        for (int i = 1; i <= 6; i++) apply(mk(0, 1, 0, 1, o_flash(3, 1, 0)), "p_flash_btn");
        apply(mk(0, 1, 0, 1, o_flash(3, 1, 1)), "p_flash_wait_led");
        apply(mk(0, 0, 1, 1, o_flash(2, 0, 1)), "p_flash_tick2");
        apply(mk(0, 0, 1, 1, o_flash(1, 1, 1)), "p_flash_tick1");
        apply(mk(0, 0, 1, 1, o_clear(1)), "p_clear");
        apply(mk(0, 0, 0, 0, o_req()), "pending_to_req");
        apply(mk(0, 0, 0, 0, o_req()), "pending_req_hold");

        // Abort: grant lost at WALK cd=3.
        apply(mk(0, 0, 0, 1, o_walk(5)), "a_walk5");
        apply(mk(0, 0, 1, 1, o_walk(4)), "a_walk4");
        apply(mk(0, 0, 1, 1, o_walk(3)), "a_walk3");
        apply(mk(0, 0, 1, 0, o_clear(0)), "abort_to_clear");

        // Press completing in the same cycle that CLEAR exits.
        for (int i = 1; i <= 6; i++) apply(mk(0, 1, 0, 1, o_clear(0)), "c_btn_wait");
        apply(mk(0, 1, 0, 0, o_req()), "clear_exit_press");

        // Reset mid-WALK, then a tick must do nothing.
        apply(mk(0, 0, 0, 1, o_walk(5)), "r_walk5");
        apply(mk(0, 0, 1, 1, o_walk(4)), "r_walk4");
        apply(mk(1, 0, 0, 1, o_idle()), "reset_mid_walk");
        apply(mk(0, 0, 1, 1, o_idle()), "post_reset_tick");
        apply(mk(0, 0, 0, 1, o_idle()), "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ped_request_unit.md
PED_REQUEST_UNIT -- requirements
Module: ped_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: consecutive stable clocks required before the debounced button changes.
REQ-002 Parameter WALK_SEC, default 5: walk interval length, in tick pulses, range 1..15.
REQ-003 Parameter FLASH_SEC, default 3: flashing don't-walk interval length, in tick pulses, range 1..15.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 btn_raw  in  1  pedestrian push-button; asynchronous, bouncy, active-high.
REQ-007 tick  in  1  one-clk-wide 1 Hz enable strobe.
REQ-008 grant  in  1  traffic controller vehicle-red indication; 1 means crossing is safe.
REQ-009 paso  out  1  crossing request level to the traffic controller.
REQ-010 walk  out  1  walk lamp.
REQ-011 dont_walk  out  1  don't-walk lamp.
REQ-012 wait_led  out  1  "request registered" indicator.
REQ-013 countdown  out  4  remaining ticks in the current WALK or FLASH interval; 0 otherwise.

Function
REQ-014 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYC consecutive clocks; any reversion SHALL restart the count.
REQ-016 A press event SHALL be the debounced 0->1 edge; it is one clock wide.
REQ-017 The FSM states SHALL be IDLE, REQ, WALK, FLASH, CLEAR; all outputs are registered.
REQ-018 IDLE: paso=0, walk=0, dont_walk=1, wait_led=0. A press event moves the FSM to REQ on the next edge.
REQ-019 REQ: paso=1, wait_led=1, dont_walk=1. grant sampled 1 moves the FSM to WALK on the next edge, with countdown loaded to WALK_SEC and paso cleared.
REQ-020 WALK: walk=1, dont_walk=0, wait_led=0. countdown decrements on each tick.
REQ-021 WALK exit: a tick with countdown==1 moves the FSM to FLASH with countdown loaded to FLASH_SEC.
REQ-022 FLASH: walk=0. dont_walk starts at 1 on entry and toggles on each tick. countdown decrements on each tick.
REQ-023 FLASH exit: a tick with countdown==1 moves the FSM to CLEAR with countdown=0.
REQ-024 CLEAR: dont_walk=1. The FSM stays in CLEAR until grant is sampled 0.
REQ-025 CLEAR exit: the FSM goes to REQ if a pending press is latched, otherwise to IDLE.
REQ-026 grant sampled 0 in WALK or FLASH SHALL force CLEAR on the next edge: walk=0, dont_walk=1, countdown=0 (safety abort).
REQ-027 Press events in REQ or WALK SHALL be ignored.
REQ-028 Press events in FLASH or CLEAR SHALL set a pending flag and wait_led=1. The flag clears on entry to REQ.
REQ-029 A press event in the same cycle as a CLEAR exit SHALL count as pending.
REQ-030 Latency: press event at edge N -> paso=1 after edge N+1.
REQ-031 Latency: grant=1 sampled at edge M -> walk=1 after edge M+1.
REQ-032 tick arriving while not in WALK or FLASH SHALL have no effect.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE from any state, including mid-WALK and mid-debounce.
REQ-034 Reset values: paso=0, walk=0, dont_walk=1, wait_led=0, countdown=0, pending=0, debounce counter=0, debounced level=0, synchronizer flops=0.
REQ-035 rst SHALL take priority over every other input.

Structure
REQ-036 A shared package ped_pkg SHALL hold the state enumeration type and default constants for WALK_SEC, FLASH_SEC and DEBOUNCE_CYC.
REQ-037 Synchronizer plus debounce plus edge detect SHALL be one sub-module, btn_debounce, instantiated once.

Verification (DEBOUNCE_CYC=4, WALK_SEC=5, FLASH_SEC=3)
REQ-038 Bounce: btn_raw toggles every 2 clks for 20 clks, then holds 1 -> exactly one press event; paso rises 2+4+1 clks after the hold starts.
REQ-039 Full cycle: press, then grant=1 three clks later -> walk after 1 clk; countdown 5,4,3,2,1 on ticks; FLASH with dont_walk 1,0,1 and countdown 3,2,1; CLEAR; grant=0 -> IDLE.
REQ-040 Abort: grant drops at WALK countdown=3 -> next edge walk=0, dont_walk=1, countdown=0, state CLEAR.
REQ-041 Pending: press during FLASH -> wait_led=1; after CLEAR and grant=0 -> REQ with paso=1, without a new press.
REQ-042 Reset mid-WALK: rst pulsed 1 clk -> all outputs at reset values next edge; a later tick causes no change.
